// File: rtl/memarbit_pkg.sv
// Shared constants and helpers for the N-port memory arbiter.
package memarbit_pkg;

  localparam int MEMARBIT_AW = 18;
  localparam int MEMARBIT_DW = 36;

  // Binary index of the set bit in a one-hot vector; 0 when no bit is set.
  function automatic int onehot2idx(input logic [15:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/memarbit_pick.sv
// Combinational winner picker: double-width rotated priority encoder.
// With MEMARBIT_N_RR_EN the scan starts after 'last', otherwise at port 0.
module memarbit_pick #(
  parameter int NPORT = 4,
  parameter int IW    = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] cyc,
  input  logic [IW-1:0]    last,
  output logic [NPORT-1:0] grant,
  output logic [IW-1:0]    idx
);

  logic [2*NPORT-1:0] dbl;
  logic [2*NPORT-1:0] rot;
  int                 start;
  int                 pos;
  logic               found;

  assign dbl = {cyc, cyc};

`ifdef MEMARBIT_N_RR_EN
  always_comb begin
    start = int'(last) + 1;
    if (start >= NPORT) start = 0;
  end
`else
  logic unused_last;
  assign unused_last = ^last;
  assign start = 0;
`endif

  // Rotating the doubled vector makes the wrap-around scan a plain
  // lowest-bit search.
  assign rot = dbl >> start;

  always_comb begin
    found = 1'b0;
    pos   = 0;
    for (int j = 0; j < NPORT; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        pos   = start + j;
      end
    end
    if (pos >= NPORT) pos = pos - NPORT;
    grant = '0;
    idx   = '0;
    if (found) begin
      grant = NPORT'(1) << pos;
      idx   = IW'(pos);
    end
  end

endmodule

// File: rtl/memarbit_n.sv
// N-port memory arbiter holding a grant for a whole client cycle.
// Define MEMARBIT_N_RR_EN for round-robin; otherwise lowest index wins.
module memarbit_n
  import memarbit_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int AW    = MEMARBIT_AW,
  parameter int DW    = MEMARBIT_DW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NPORT*AW-1:0]       s_address,
  input  logic [NPORT-1:0]          s_write,
  input  logic [NPORT-1:0]          s_read,
  input  logic [NPORT*DW-1:0]       s_writedata,
  output logic [NPORT*DW-1:0]       s_readdata,
  output logic [NPORT-1:0]          s_waitrequest,
  output logic [AW-1:0]             m_address,
  output logic                      m_write,
  output logic                      m_read,
  output logic [DW-1:0]             m_writedata,
  input  logic [DW-1:0]             m_readdata,
  input  logic                      m_waitrequest,
  output logic [$clog2(NPORT)-1:0]  owner,
  output logic                      busy
);

  localparam int IW = $clog2(NPORT);

  logic [NPORT-1:0] cyc;
  logic [NPORT-1:0] sel_reg, sel_next;
  logic [NPORT-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    pick_last;

  assign cyc = s_read | s_write;

`ifdef MEMARBIT_N_RR_EN
  logic [IW-1:0] last_reg, last_next;
  assign pick_last = last_reg;
`else
  logic unused_idx;
  assign unused_idx = ^pick_idx;
  assign pick_last  = '0;
`endif

  memarbit_pick #(.NPORT(NPORT), .IW(IW)) u_pick (
    .cyc   (cyc),
    .last  (pick_last),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_reg  <= '0;
`ifdef MEMARBIT_N_RR_EN
      last_reg <= IW'(NPORT - 1);
`endif
    end else begin
      sel_reg  <= sel_next;
`ifdef MEMARBIT_N_RR_EN
      last_reg <= last_next;
`endif
    end
  end

  // A held grant is only released by its owner dropping cyc; no preemption.
  always_comb begin
    sel_next  = sel_reg;
`ifdef MEMARBIT_N_RR_EN
    last_next = last_reg;
`endif
    if (sel_reg == '0) begin
      if (|cyc) begin
        sel_next  = pick_grant;
`ifdef MEMARBIT_N_RR_EN
        last_next = pick_idx;
`endif
      end
    end else if ((sel_reg & cyc) == '0) begin
      sel_next = '0;
    end
  end

  always_comb begin
    m_address     = '0;
    m_write       = 1'b0;
    m_read        = 1'b0;
    m_writedata   = '0;
    s_readdata    = '0;
    s_waitrequest = '1;
    for (int i = 0; i < NPORT; i++) begin
      if (sel_reg[i]) begin
        m_address                = s_address[i*AW +: AW];
        m_write                  = s_write[i];
        m_read                   = s_read[i];
        m_writedata              = s_writedata[i*DW +: DW];
        s_readdata[i*DW +: DW]   = m_readdata;
        s_waitrequest[i]         = m_waitrequest;
      end
    end
  end

  assign busy  = |sel_reg;
  assign owner = IW'(onehot2idx(16'(sel_reg)));

endmodule
